// File: rtl/disk_ctrl.sv
// rtl/disk_ctrl.sv - DMA word mover between a RAM transfer port and a disk request port.
// Define DISK_CTRL_CHECKSUM_EN to build the running word-sum checksum; otherwise checksum is tied to 0.
module disk_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  dir,
  input  logic [ADDR_WIDTH-1:0] ram_base,
  input  logic [ADDR_WIDTH-1:0] disk_base,
  input  logic [ADDR_WIDTH-1:0] len,
  input  logic [DATA_WIDTH-1:0] q_t,
  output logic [ADDR_WIDTH-1:0] addr_t,
  output logic [DATA_WIDTH-1:0] data_t,
  output logic                  tr,
  output logic                  ldd,
  output logic [ADDR_WIDTH-1:0] disk_addr,
  output logic                  disk_rd,
  output logic                  disk_wr,
  output logic [DATA_WIDTH-1:0] disk_wdata,
  input  logic [DATA_WIDTH-1:0] disk_rdata,
  input  logic                  disk_ready,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum
);

  typedef enum logic [2:0] {IDLE, DRD, RWR, RRD, DWR, FIN} state_t;

  state_t                  state, state_nx;
  logic [ADDR_WIDTH-1:0]   ram_ptr, disk_ptr, cnt;
  logic [DATA_WIDTH-1:0]   word_buf;
  logic                    load, advance, cap_en;
  logic [DATA_WIDTH-1:0]   cap_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // All outputs decode from state, so reset forces every strobe low without waiting for a clock.
  always_comb begin
    state_nx   = state;
    load       = 1'b0;
    advance    = 1'b0;
    cap_en     = 1'b0;
    cap_data   = '0;
    addr_t     = '0;
    data_t     = '0;
    tr         = 1'b0;
    disk_addr  = '0;
    disk_rd    = 1'b0;
    disk_wr    = 1'b0;
    disk_wdata = '0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          load = 1'b1;
          if (len == '0) state_nx = FIN;
          else           state_nx = dir ? RRD : DRD;
        end
      end
      DRD: begin
        disk_rd   = 1'b1;
        disk_addr = disk_ptr;
        if (disk_ready) begin
          cap_en   = 1'b1;
          cap_data = disk_rdata;
          state_nx = RWR;
        end
      end
      RWR: begin
        tr      = 1'b1;
        addr_t  = ram_ptr;
        data_t  = word_buf;
        advance = 1'b1;
      end
      RRD: begin
        addr_t   = ram_ptr;
        cap_en   = 1'b1;
        cap_data = q_t;
        state_nx = DWR;
      end
      DWR: begin
        disk_wr    = 1'b1;
        disk_addr  = disk_ptr;
        disk_wdata = word_buf;
        if (disk_ready) advance = 1'b1;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (advance) begin
      if (cnt == ADDR_WIDTH'(1)) state_nx = FIN;
      else                       state_nx = (state == RWR) ? DRD : RRD;
    end
  end

  assign ldd = busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_ptr  <= '0;
      disk_ptr <= '0;
      cnt      <= '0;
      word_buf <= '0;
    end else begin
      if (load) begin
        ram_ptr  <= ram_base;
        disk_ptr <= disk_base;
        cnt      <= len;
      end else if (advance) begin
        ram_ptr  <= ram_ptr + ADDR_WIDTH'(1);
        disk_ptr <= disk_ptr + ADDR_WIDTH'(1);
        cnt      <= cnt - ADDR_WIDTH'(1);
      end
      if (cap_en) word_buf <= cap_data;
    end
  end

`ifdef DISK_CTRL_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      sum_q <= '0;
    else if (load)   sum_q <= '0;
    else if (cap_en) sum_q <= sum_q + cap_data;
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_disk_ctrl.sv
// tb/tb_disk_ctrl.sv - table-driven scoreboard bench for disk_ctrl with RAM and disk models.
module tb_disk_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, dir;
  logic [15:0] ram_base, disk_base, len;
  logic [15:0] q_t, addr_t, data_t, disk_addr, disk_wdata, disk_rdata, checksum;
  logic        tr, ldd, disk_rd, disk_wr, disk_ready, busy, done;

  disk_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir),
    .ram_base(ram_base), .disk_base(disk_base), .len(len),
    .q_t(q_t), .addr_t(addr_t), .data_t(data_t), .tr(tr), .ldd(ldd),
    .disk_addr(disk_addr), .disk_rd(disk_rd), .disk_wr(disk_wr),
    .disk_wdata(disk_wdata), .disk_rdata(disk_rdata), .disk_ready(disk_ready),
    .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  logic [15:0] ram  [0:65535];
  logic [15:0] disk [0:65535];
  assign q_t = ram[addr_t];

  typedef struct {
    logic        kind;
    logic [15:0] addr;
    logic [15:0] data;
  } sb_t;
  sb_t sb[$];

  int   wait_cycles = 0;
  int   wcnt = 0;
  logic prev_rd = 1'b0;
  logic prev_ready = 1'b0;
  logic [15:0] prev_addr = '0;

  always @(posedge clk) begin
    if (tr) ram[addr_t] = data_t;
    if (disk_wr && disk_ready) disk[disk_addr] = disk_wdata;
  end

  // Disk responder then monitor, in one process so their order at each falling edge is fixed.
  always @(negedge clk) begin
    sb_t e;
    if (!rst_n) begin
      disk_ready = 1'b0;
      wcnt = 0;
    end else if ((disk_rd || disk_wr) && !disk_ready) begin
      if (wcnt >= wait_cycles) begin
        disk_ready = 1'b1;
        disk_rdata = disk[disk_addr];
      end else begin
        wcnt++;
      end
    end else begin
      disk_ready = 1'b0;
      wcnt = 0;
    end

    if (disk_rd && disk_wr) chk("rd_wr_exclusive", 1, 0);
    if (disk_rd && prev_rd && !prev_ready) chk("disk_addr_stable", disk_addr, prev_addr);
    prev_rd = disk_rd;
    prev_ready = disk_ready;
    prev_addr = disk_addr;

    if (tr || (disk_wr && disk_ready)) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", {tr, disk_wr}, 0);
      end else begin
        e = sb.pop_front();
        chk("write_kind", {31'd0, disk_wr}, {31'd0, e.kind});
        if (tr) begin
          chk("ram_addr", addr_t, e.addr);
          chk("ram_data", data_t, e.data);
        end else begin
          chk("disk_addr", disk_addr, e.addr);
          chk("disk_wdata", disk_wdata, e.data);
        end
      end
    end
  end

  typedef struct {
    logic        dir;
    logic [15:0] ram_base;
    logic [15:0] disk_base;
    logic [15:0] len;
    int          wait_c;
    logic        noise;
    int          lat;
  } vec_t;

  task automatic run_vec(input vec_t v);
    logic [15:0] a, d, w, sum;
    int cyc;
    bit got;
    sum = '0;
    for (int i = 0; i < int'(v.len); i++) begin
      a = v.ram_base + 16'(i);
      d = v.disk_base + 16'(i);
      if (!v.dir) begin w = disk[d]; sb.push_back('{1'b0, a, w}); end
      else        begin w = ram[a];  sb.push_back('{1'b1, d, w}); end
      sum = sum + w;
    end
`ifndef DISK_CTRL_CHECKSUM_EN
    sum = '0;
`endif
    wait_cycles = v.wait_c;
    @(negedge clk);
    dir = v.dir; ram_base = v.ram_base; disk_base = v.disk_base; len = v.len;
    start = 1'b1;
    cyc = 1;
    got = 0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (done) got = 1;
      else start = v.noise ? 1'($urandom_range(1, 0)) : 1'b0;
      if (!got) chk("busy_during", {ldd, busy}, 2'b11);
    end
    chk("latency", cyc, got ? v.lat : -1);
    chk("checksum_done", checksum, sum);
    start = v.noise;
    @(negedge clk);
    start = 1'b0;
    chk("idle_after_fin", {busy, done, ldd}, 3'b000);
    chk("checksum_hold", checksum, sum);
    chk("sb_empty", sb.size(), 0);
    if (!v.dir)
      for (int i = 0; i < int'(v.len); i++)
        chk("ram_content", ram[v.ram_base + 16'(i)], disk[v.disk_base + 16'(i)]);
  endtask

  vec_t vecs[7];

  initial begin
    int n;
    for (int i = 0; i < 65536; i++) begin
      ram[i]  = 16'(i) ^ 16'h5A5A;
      disk[i] = 16'(i * 3 + 1);
    end
    disk[16'h0200] = 16'hAAAA; disk[16'h0201] = 16'hBBBB; disk[16'h0202] = 16'hCCCC;
    vecs[0] = '{1'b0, 16'h0010, 16'h0200, 16'd3, 0, 1'b0, 8};
    vecs[1] = '{1'b1, 16'hFFFF, 16'h0300, 16'd2, 0, 1'b0, 6};
    vecs[2] = '{1'b0, 16'h0020, 16'h0220, 16'd0, 0, 1'b1, 2};
    vecs[3] = '{1'b0, 16'h0040, 16'h0210, 16'd2, 5, 1'b1, 16};
    vecs[4] = '{1'b1, 16'h0010, 16'h0400, 16'd3, 2, 1'b1, 14};
    vecs[5] = '{1'b0, 16'h0080, 16'hFFFF, 16'd2, 1, 1'b0, 8};
    vecs[6] = '{1'b1, 16'h0090, 16'h0500, 16'd0, 0, 1'b1, 2};

    rst_n = 1'b0; start = 1'b0; dir = 1'b0;
    ram_base = '0; disk_base = '0; len = '0;
    disk_rdata = '0; disk_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_strobes", {busy, done, tr, ldd, disk_rd, disk_wr}, 6'b0);
    chk("reset_addr_t", addr_t, 0);
    chk("reset_data_t", data_t, 0);
    chk("reset_disk_addr", disk_addr, 0);
    chk("reset_disk_wdata", disk_wdata, 0);
    chk("reset_checksum", checksum, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Abort a 4-word load while word 2 is being written to RAM.
    for (int i = 0; i < 4; i++) begin
      ram[16'h0100 + 16'(i)]  = 16'hDEAD;
      disk[16'h0600 + 16'(i)] = 16'h1111 * 16'(i + 1);
    end
    sb.push_back('{1'b0, 16'h0100, 16'h1111});
    sb.push_back('{1'b0, 16'h0101, 16'h2222});
    wait_cycles = 0;
    @(negedge clk);
    dir = 1'b0; ram_base = 16'h0100; disk_base = 16'h0600; len = 16'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = (tr === 1'b1) ? 1 : 0;
    for (int c = 0; c < 40 && n < 2; c++) begin
      @(negedge clk);
      if (tr) n++;
    end
    chk("abort_reached_word2", n, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_immediate", {tr, ldd, busy, disk_rd, disk_wr}, 5'b0);
    chk("abort_sb", sb.size(), 0);
    @(negedge clk);
    chk("abort_held", {tr, ldd, busy, done}, 4'b0);
    chk("abort_word1", ram[16'h0100], 16'h1111);
    chk("abort_word2", ram[16'h0101], 16'hDEAD);
    rst_n = 1'b1;
    sb.delete();
    repeat (3) @(negedge clk);
    chk("after_abort_idle", {busy, tr, disk_rd}, 3'b0);
    chk("after_abort_word3", ram[16'h0102], 16'hDEAD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
